// File: rtl/ef_pkg.sv
// Shared definitions for the multi-channel extremum finder.
// Sentinels, mode constants and FSM encodings.
package ef_pkg;

    localparam logic EF_MODE_WINDOW = 1'b0;
    localparam logic EF_MODE_HOLD   = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } ef_state_t;

    // Returned 64 bits wide; callers keep the low w bits.
    function automatic logic [63:0] ef_pos_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] ef_neg_max(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/extremum_finder_mc_channel.sv
// Per-channel min/max accumulator with shifted threshold publish.
// Publish sees the accumulators including the beat of the same cycle.
module ef_channel
    import ef_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_beat,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic                         i_clear_acc,
    input  logic                         i_publish,
    input  logic                         i_reload,
    input  logic [2:0]                   i_shift,
    output logic signed [DATA_WIDTH-1:0] o_lower,
    output logic signed [DATA_WIDTH-1:0] o_upper,
    output logic signed [DATA_WIDTH-1:0] o_offset
);

    localparam int W = DATA_WIDTH;
    localparam logic [63:0] POS64 = ef_pos_max(W);
    localparam logic [63:0] NEG64 = ef_neg_max(W);
    localparam logic signed [W-1:0] POS = POS64[W-1:0];
    localparam logic signed [W-1:0] NEG = NEG64[W-1:0];

    logic signed [W-1:0] r_min;
    logic signed [W-1:0] r_max;
    logic signed [W-1:0] r_lower;
    logic signed [W-1:0] r_upper;
    logic signed [W-1:0] r_offset;

    logic signed [W-1:0] w_base_min;
    logic signed [W-1:0] w_base_max;
    logic signed [W-1:0] w_min;
    logic signed [W-1:0] w_max;
    logic signed [W-1:0] w_lower;
    logic signed [W-1:0] w_upper;
    logic signed [W:0]   w_sum;
    logic signed [W:0]   w_half;

    assign w_base_min = i_clear_acc ? POS : r_min;
    assign w_base_max = i_clear_acc ? NEG : r_max;

    assign w_min = (i_beat && (i_sample < w_base_min)) ? i_sample : w_base_min;
    assign w_max = (i_beat && (i_sample > w_base_max)) ? i_sample : w_base_max;

    assign w_lower = w_min >>> i_shift;
    assign w_upper = w_max >>> i_shift;

    // One extra bit keeps the midpoint sum from overflowing.
    assign w_sum  = {w_lower[W-1], w_lower} + {w_upper[W-1], w_upper};
    assign w_half = w_sum >>> 1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_min    <= POS;
            r_max    <= NEG;
            r_lower  <= POS;
            r_upper  <= NEG;
            r_offset <= '0;
        end else begin
            if (i_publish && i_reload) begin
                r_min <= POS;
                r_max <= NEG;
            end else begin
                r_min <= w_min;
                r_max <= w_max;
            end
            if (i_publish) begin
                r_lower  <= w_lower;
                r_upper  <= w_upper;
                r_offset <= w_half[W-1:0];
            end
        end
    end

    assign o_lower  = r_lower;
    assign o_upper  = r_upper;
    assign o_offset = r_offset;

endmodule

// File: rtl/extremum_finder_mc.sv
// Multi-channel windowed / peak-hold extremum finder.
// Stream passes through untouched; thresholds publish once per window.
module extremum_finder_mc
    import ef_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNEL_COUNT = 2,
    parameter int MAX_LOG_COUNT = 20
) (
    input  logic                                  SYS_aclk,
    input  logic                                  SYS_reset,
    input  logic                                  EF_enable,
    input  logic                                  EF_mode,
    input  logic                                  EF_clear,
    input  logic [4:0]                            EF_log_count,
    input  logic [2:0]                            EF_log_shift,
    output logic [CHANNEL_COUNT*DATA_WIDTH-1:0]   EF_lower_threshold,
    output logic [CHANNEL_COUNT*DATA_WIDTH-1:0]   EF_upper_threshold,
    output logic [CHANNEL_COUNT*DATA_WIDTH-1:0]   EF_offset,
    output logic                                  EF_update,
    input  logic                                  S_AXIS_tvalid,
    input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0]   S_AXIS_tdata,
    output logic                                  S_AXIS_tready,
    output logic                                  M_AXIS_tvalid,
    output logic [CHANNEL_COUNT*DATA_WIDTH-1:0]   M_AXIS_tdata,
    input  logic                                  M_AXIS_tready
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = MAX_LOG_COUNT;
    localparam logic [CW:0]   ONE_SPAN  = {{CW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_COUNT = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [4:0]    LOG_MAX   = 5'(MAX_LOG_COUNT);

    ef_state_t     r_state;
    ef_state_t     w_next;
    logic [CW-1:0] r_count;
    logic [4:0]    r_log;
    logic [2:0]    r_shift;
    logic          r_update;

    logic          w_accept;
    logic          w_beat;
    logic          w_clear;
    logic          w_publish;
    logic          w_latch;
    logic          w_last;
    logic          w_reload;
    logic [4:0]    w_log_clamped;
    logic [CW:0]   w_span;

    assign S_AXIS_tready = M_AXIS_tready;
    assign M_AXIS_tvalid = S_AXIS_tvalid;
    assign M_AXIS_tdata  = S_AXIS_tdata;

    assign w_accept      = S_AXIS_tvalid & M_AXIS_tready;
    assign w_log_clamped = (EF_log_count > LOG_MAX) ? LOG_MAX : EF_log_count;
    assign w_span        = ONE_SPAN << r_log;
    assign w_last        = ({1'b0, r_count} == (w_span - ONE_SPAN));
    assign w_reload      = (EF_mode != EF_MODE_HOLD);

    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_beat    = 1'b0;
        w_clear   = 1'b1;
        w_publish = 1'b0;
        w_latch   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (EF_enable) begin
                    w_next  = ST_MEASURE;
                    w_latch = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!EF_enable) begin
                    w_next = ST_IDLE;
                end else begin
                    w_clear   = EF_clear;
                    w_beat    = w_accept;
                    w_publish = w_accept && !EF_clear && w_last;
                    w_latch   = w_publish;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A beat coinciding with a clear seeds the fresh window.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            r_count  <= '0;
            r_log    <= '0;
            r_shift  <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_publish;
            if (w_clear) begin
                r_count <= w_beat ? ONE_COUNT : '0;
            end else if (w_publish) begin
                r_count <= '0;
            end else if (w_beat) begin
                r_count <= r_count + ONE_COUNT;
            end
            if (w_latch) begin
                r_log   <= w_log_clamped;
                r_shift <= EF_log_shift;
            end
        end
    end

    assign EF_update = r_update;

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
        ef_channel #(
            .DATA_WIDTH(W)
        ) u_ch (
            .i_clk      (SYS_aclk),
            .i_reset    (SYS_reset),
            .i_beat     (w_beat),
            .i_sample   (S_AXIS_tdata[c*W +: W]),
            .i_clear_acc(w_clear),
            .i_publish  (w_publish),
            .i_reload   (w_reload),
            .i_shift    (r_shift),
            .o_lower    (EF_lower_threshold[c*W +: W]),
            .o_upper    (EF_upper_threshold[c*W +: W]),
            .o_offset   (EF_offset[c*W +: W])
        );
    end

endmodule

// File: doc/extremum_finder_mc.md
Name: extremum_finder_mc

Overview:
- Multi-channel, parametrised successor to the single-channel extremum finder.
- Tracks signed min/max per channel over a window of 2^EF_log_count accepted AXI-Stream beats and publishes arithmetically shifted thresholds plus a midpoint offset per channel.
- Supports windowed mode (accumulators restart every window) and peak-hold mode (accumulators persist until EF_clear).
- Sits in-line on the sample stream ahead of the threshold/phase logic; data passes through unmodified with zero latency.

Parameters:
DATA_WIDTH, 16, signed sample width per channel
CHANNEL_COUNT, 2, channels packed in tdata, channel 0 in the LSBs
MAX_LOG_COUNT, 20, upper clamp applied to EF_log_count

Ports:
SYS_aclk  in  1  system clock
SYS_reset  in  1  synchronous, active-high reset
EF_enable  in  1  0 = idle, accumulators cleared, outputs held
EF_mode  in  1  0 = windowed, 1 = peak-hold
EF_clear  in  1  one-cycle pulse, restarts accumulators in either mode
EF_log_count  in  5  window length = 2^min(EF_log_count, MAX_LOG_COUNT) beats
EF_log_shift  in  3  arithmetic right shift applied at publish
EF_lower_threshold  out  CHANNEL_COUNT*DATA_WIDTH  shifted minimum per channel
EF_upper_threshold  out  CHANNEL_COUNT*DATA_WIDTH  shifted maximum per channel
EF_offset  out  CHANNEL_COUNT*DATA_WIDTH  (lower + upper) >>> 1 per channel
EF_update  out  1  one-cycle pulse when outputs change
S_AXIS_tvalid  in  1  input beat valid
S_AXIS_tdata  in  CHANNEL_COUNT*DATA_WIDTH  input samples
S_AXIS_tready  out  1  = M_AXIS_tready
M_AXIS_tvalid  out  1  = S_AXIS_tvalid
M_AXIS_tdata  out  CHANNEL_COUNT*DATA_WIDTH  = S_AXIS_tdata
M_AXIS_tready  in  1  downstream ready

Behaviour:
- Clock and reset: single clock SYS_aclk. Reset is synchronous and active-high; SYS_reset takes effect on the SYS_aclk edge at which it is sampled high.
- Reset values:
  - lower = +max (0x7FFF at W=16).
  - upper = -max (0x8000).
  - offset = 0.
  - EF_update = 0.
  - count = 0.
  - state = IDLE.
  - Accumulators at sentinels.
- Beat: accepted only when S_AXIS_tvalid & M_AXIS_tready. Non-accepted cycles change no accumulator or counter.
- Config latch: log_count (clamped) and log_shift are latched on entering MEASURE and at each window boundary. Mid-window changes take effect at the next window.
- FSM IDLE:
  - Accumulators at sentinels, count = 0.
  - Moves to MEASURE when EF_enable = 1 (latching config).
- FSM MEASURE, per accepted beat:
  - acc_min = smin(acc_min, x) and acc_max = smax(acc_max, x) per channel.
  - count++.
- Last beat (count == 2^L - 1, accepted):
  - Publish uses the min/max including that beat.
  - Outputs register on the next edge, so latency is 1 clock after the accepted last beat.
  - EF_update pulses high for that one cycle.
  - count resets to 0 and config is relatched.
  - Mode 0: accumulators reload to sentinels on the same edge.
  - Mode 1: accumulators retained.
- Publish arithmetic:
  - lower = $signed(acc_min) >>> shift, upper = $signed(acc_max) >>> shift.
  - offset = (lower + upper) >>> 1, using a DATA_WIDTH+1 sum and truncation to DATA_WIDTH (no overflow possible).
- EF_clear in MEASURE:
  - Accumulators go to sentinels and count = 0.
  - An accepted beat in the same cycle seeds the new accumulators (count = 1).
  - Outputs are held, no EF_update.
- EF_enable = 0 in MEASURE: go to IDLE next edge; outputs keep their last published values.
- L = 0: every accepted beat is a window (EF_update after each beat).
- Back-to-back windows: no dead cycle; a beat accepted on the cycle after the last beat counts in the new window.
- Reset mid-window: all state returns to reset values and no publish occurs.

Decomposition:
- Package ef_pkg:
  - Sentinel functions for DATA_WIDTH (ef_pos_max, ef_neg_max).
  - Mode constants EF_MODE_WINDOW = 0, EF_MODE_HOLD = 1.
  - State encodings IDLE/MEASURE.
- Sub-module ef_channel (one per channel, via generate): holds acc_min/acc_max and performs the shift/offset publish. Inputs: beat, sample, clear_acc, publish, shift.
- Top level: FSM, counter, config latch, stream pass-through.

Test Plan:
- W=16, CH=2, log_count=2, shift=0, mode 0; ch0 = 5, -3, 7, 1 and ch1 = -100, 50, 0, 20 → after the 4th accepted beat + 1 clk: lower = {-100, -3}, upper = {50, 7}, offset = {-25, 2}, one EF_update pulse.
- Same input with shift=2 → lower0 = -1, upper0 = 1, lower1 = -25, upper1 = 12, offset1 = -7.
- M_AXIS_tready toggles 0/1 with tvalid = 1 for 8 cycles, log_count=2 → exactly one EF_update, only after the 4th handshake.
- Mode 1, window 1 peaks ch0 = 9, window 2 max ch0 = 4 → upper0 stays 9. EF_clear, then window 3 max 4 → upper0 = 4.
- log_count changed 2→3 mid-window → current window ends after 4 beats, next after 8.
- Reset asserted after 2 of 4 beats → outputs return to 0x7FFF/0x8000/0, no EF_update; the next full window publishes correctly.
